fork2_fifo: RTL and testbench

Buffered two-way fork: the producer-side counterpart of the two-input join. One valid/ready input stream is broadcast to two independent valid/ready output streams. Each branch has its own DEPTH-entry FIFO, so the two consumers can accept at different times and drift apart by up to DEPTH words. Sits wherever one activation/MX block stream feeds two downstream pipelines, e.g. a residual path plus a compute path.

---
 rtl/fork2_fifo.sv | 80 ++++++++
 tb/tb_fork2_fifo.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fork2_fifo.sv
// Buffered two-way fork: one valid/ready stream is broadcast into two
// independent per-branch circular FIFOs so the two consumers may drift apart.
module fork2_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2,
    localparam int CW        = $clog2(DEPTH + 1),
    localparam int PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic [DATA_WIDTH-1:0] data_out_0,
    output logic [DATA_WIDTH-1:0] data_out_1,
    output logic [1:0]            data_out_valid,
    input  logic [1:0]            data_out_ready,
    output logic [CW-1:0]         count_0,
    output logic [CW-1:0]         count_1
);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic                             push;
    logic [PW-1:0]                    wr_ptr;
    logic [1:0][DATA_WIDTH-1:0]       head;
    logic [1:0][CW-1:0]               cnt;

    // Both branches are always written together, so one write pointer serves both.
    assign data_in_ready = rst & (cnt[0] != CW'(DEPTH)) & (cnt[1] != CW'(DEPTH));
    assign push          = data_in_valid & data_in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            wr_ptr <= '0;
        else if (push)
            wr_ptr <= ptr_inc(wr_ptr);
    end

    for (genvar b = 0; b < 2; b++) begin : g_branch
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic [PW-1:0]         rd_ptr;
        logic [CW-1:0]         count;
        logic                  pop;

        assign data_out_valid[b] = (count != '0);
        assign pop               = data_out_valid[b] & data_out_ready[b];
        assign head[b]           = data_out_valid[b] ? mem[rd_ptr] : '0;
        assign cnt[b]            = count;

        // Storage is deliberately left unreset; only pointers and counts clear.
        always_ff @(posedge clk) begin
            if (push)
                mem[wr_ptr] <= data_in;
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (pop)
                    rd_ptr <= ptr_inc(rd_ptr);
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    assign data_out_0 = head[0];
    assign data_out_1 = head[1];
    assign count_0    = cnt[0];
    assign count_1    = cnt[1];

endmodule

// File: tb/tb_fork2_fifo.sv
// Directed bench for fork2_fifo: table-driven vectors on a DEPTH=2 instance,
// plus hand sequences on DEPTH=1 and DEPTH=3 instances and a mid-stream reset.
module tb_fork2_fifo;

    logic clk = 1'b0;
    logic rst;

    logic [31:0] a_in, a_out0, a_out1;
    logic        a_valid, a_ready;
    logic [1:0]  a_out_valid, a_out_ready, a_c0, a_c1;

    logic [31:0] b_in, b_out0, b_out1;
    logic        b_valid, b_ready;
    logic [1:0]  b_out_valid, b_out_ready;
    logic [0:0]  b_c0, b_c1;

    logic [31:0] c_in, c_out0, c_out1;
    logic        c_valid, c_ready;
    logic [1:0]  c_out_valid, c_out_ready, c_c0, c_c1;

    int tests    = 0;
    int failures = 0;

    typedef struct {
        logic        in_valid;
        logic [31:0] in_data;
        logic [1:0]  out_ready;
        logic        exp_ready;
        logic [1:0]  exp_valid;
        logic [31:0] exp_d0;
        logic [31:0] exp_d1;
        logic [1:0]  exp_c0;
        logic [1:0]  exp_c1;
    } vec_t;

    vec_t vecs[$];

    fork2_fifo #(.DATA_WIDTH(32), .DEPTH(2)) u_d2 (
        .clk(clk), .rst(rst), .data_in(a_in), .data_in_valid(a_valid),
        .data_in_ready(a_ready), .data_out_0(a_out0), .data_out_1(a_out1),
        .data_out_valid(a_out_valid), .data_out_ready(a_out_ready),
        .count_0(a_c0), .count_1(a_c1));

    fork2_fifo #(.DATA_WIDTH(32), .DEPTH(1)) u_d1 (
        .clk(clk), .rst(rst), .data_in(b_in), .data_in_valid(b_valid),
        .data_in_ready(b_ready), .data_out_0(b_out0), .data_out_1(b_out1),
        .data_out_valid(b_out_valid), .data_out_ready(b_out_ready),
        .count_0(b_c0), .count_1(b_c1));

    fork2_fifo #(.DATA_WIDTH(32), .DEPTH(3)) u_d3 (
        .clk(clk), .rst(rst), .data_in(c_in), .data_in_valid(c_valid),
        .data_in_ready(c_ready), .data_out_0(c_out0), .data_out_1(c_out1),
        .data_out_valid(c_out_valid), .data_out_ready(c_out_ready),
        .count_0(c_c0), .count_1(c_c1));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic iv, input logic [31:0] id, input logic [1:0] ordy,
                           input logic er, input logic [1:0] ev, input logic [31:0] d0,
                           input logic [31:0] d1, input logic [1:0] c0, input logic [1:0] c1);
        vec_t v;
        v.in_valid = iv; v.in_data = id; v.out_ready = ordy;
        v.exp_ready = er; v.exp_valid = ev; v.exp_d0 = d0; v.exp_d1 = d1;
        v.exp_c0 = c0; v.exp_c1 = c1;
        vecs.push_back(v);
    endtask

    task automatic apply_stimulus(input vec_t v);
        a_valid     = v.in_valid;
        a_in        = v.in_data;
        a_out_ready = v.out_ready;
    endtask

    task automatic check_output(input vec_t v, input int idx);
        check($sformatf("vec%0d in_ready", idx), 32'(a_ready), 32'(v.exp_ready));
        check($sformatf("vec%0d out_valid", idx), 32'(a_out_valid), 32'(v.exp_valid));
        check($sformatf("vec%0d data0", idx), a_out0, v.exp_d0);
        check($sformatf("vec%0d data1", idx), a_out1, v.exp_d1);
        check($sformatf("vec%0d count0", idx), 32'(a_c0), 32'(v.exp_c0));
        check($sformatf("vec%0d count1", idx), 32'(a_c1), 32'(v.exp_c1));
    endtask

    task automatic step_d1(input logic iv, input logic [31:0] id, input logic er,
                           input logic [1:0] ev, input logic [31:0] ed, input int idx);
        @(posedge clk);
        #1;
        b_valid = iv;
        b_in    = id;
        #1;
        check($sformatf("d1 step%0d in_ready", idx), 32'(b_ready), 32'(er));
        check($sformatf("d1 step%0d out_valid", idx), 32'(b_out_valid), 32'(ev));
        check($sformatf("d1 step%0d data0", idx), b_out0, ed);
        check($sformatf("d1 step%0d data1", idx), b_out1, ed);
    endtask

    initial begin
        int q0[$];
        int q1[$];
        int next_word;
        int cyc;
        logic exp_rdy;

        // Streaming: 8 back-to-back words, both consumers always ready.
        for (int k = 0; k < 10; k++) begin
            logic act;
            act = (k >= 1) && (k <= 8);
            add_vec(k < 8, (k < 8) ? 32'(k + 1) : 32'h0, 2'b11, 1'b1,
                    act ? 2'b11 : 2'b00, act ? 32'(k) : 32'h0, act ? 32'(k) : 32'h0,
                    act ? 2'd1 : 2'd0, act ? 2'd1 : 2'd0);
        end
        // Branch 1 stalled until it fills, then released.
        add_vec(1, 32'h10, 2'b01, 1, 2'b00, 32'h0,  32'h0,  2'd0, 2'd0);
        add_vec(1, 32'h11, 2'b01, 1, 2'b11, 32'h10, 32'h10, 2'd1, 2'd1);
        add_vec(1, 32'h12, 2'b01, 0, 2'b11, 32'h11, 32'h10, 2'd1, 2'd2);
        add_vec(1, 32'h12, 2'b01, 0, 2'b10, 32'h0,  32'h10, 2'd0, 2'd2);
        add_vec(1, 32'h12, 2'b11, 0, 2'b10, 32'h0,  32'h10, 2'd0, 2'd2);
        add_vec(1, 32'h12, 2'b11, 1, 2'b10, 32'h0,  32'h11, 2'd0, 2'd1);
        add_vec(0, 32'h0,  2'b11, 1, 2'b11, 32'h12, 32'h12, 2'd1, 2'd1);
        add_vec(0, 32'h0,  2'b11, 1, 2'b00, 32'h0,  32'h0,  2'd0, 2'd0);

        rst = 1'b0;
        a_valid = 1'b1; a_in = 32'hdead; a_out_ready = 2'b11;
        b_valid = 1'b1; b_in = 32'hbeef; b_out_ready = 2'b11;
        c_valid = 1'b1; c_in = 32'hcafe; c_out_ready = 2'b11;
        #2;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 32'(a_ready), 32'h0);
        check("reset out_valid", 32'(a_out_valid), 32'h0);
        check("reset count0", 32'(a_c0), 32'h0);
        check("reset count1", 32'(a_c1), 32'h0);
        check("reset data0", a_out0, 32'h0);
        check("reset data1", a_out1, 32'h0);
        check("reset d1 in_ready", 32'(b_ready), 32'h0);
        a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("release in_ready d2", 32'(a_ready), 32'h1);
        check("release in_ready d1", 32'(b_ready), 32'h1);
        check("release in_ready d3", 32'(c_ready), 32'h1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            apply_stimulus(vecs[i]);
            #1;
            check_output(vecs[i], i);
        end
        a_valid = 1'b0;

        // DEPTH=1: full branch blocks input even while popping; one word per two cycles.
        b_out_ready = 2'b11;
        step_d1(1, 32'h20, 1, 2'b00, 32'h0,  0);
        step_d1(1, 32'h21, 0, 2'b11, 32'h20, 1);
        step_d1(1, 32'h21, 1, 2'b00, 32'h0,  2);
        step_d1(1, 32'h22, 0, 2'b11, 32'h21, 3);
        step_d1(1, 32'h22, 1, 2'b00, 32'h0,  4);
        step_d1(0, 32'h0,  0, 2'b11, 32'h22, 5);
        step_d1(0, 32'h0,  1, 2'b00, 32'h0,  6);

        // DEPTH=3: random per-branch ready against a queue model of each branch.
        next_word = 0;
        cyc = 0;
        while (cyc < 300 && !(next_word == 10 && q0.size() == 0 && q1.size() == 0)) begin
            @(posedge clk);
            #1;
            c_out_ready = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
            c_valid     = (next_word < 10);
            c_in        = (next_word < 10) ? 32'h30 + 32'(next_word) : 32'h0;
            #1;
            exp_rdy = (q0.size() != 3) && (q1.size() != 3);
            check("d3 in_ready", 32'(c_ready), 32'(exp_rdy));
            check("d3 count0", 32'(c_c0), 32'(q0.size()));
            check("d3 count1", 32'(c_c1), 32'(q1.size()));
            check("d3 valid0", 32'(c_out_valid[0]), 32'(q0.size() != 0));
            check("d3 valid1", 32'(c_out_valid[1]), 32'(q1.size() != 0));
            check("d3 data0", c_out0, (q0.size() != 0) ? 32'(q0[0]) : 32'h0);
            check("d3 data1", c_out1, (q1.size() != 0) ? 32'(q1[0]) : 32'h0);
            if (q0.size() != 0 && c_out_ready[0]) void'(q0.pop_front());
            if (q1.size() != 0 && c_out_ready[1]) void'(q1.pop_front());
            if (c_valid && exp_rdy) begin
                q0.push_back(32'h30 + next_word);
                q1.push_back(32'h30 + next_word);
                next_word++;
            end
            cyc++;
        end
        check("d3 drained within budget", 32'(next_word == 10 && q0.size() == 0 && q1.size() == 0), 32'h1);
        c_valid = 1'b0;

        // Mid-stream asynchronous reset with two words parked in branch 1.
        @(posedge clk);
        #1;
        a_out_ready = 2'b01; a_valid = 1'b1; a_in = 32'h40;
        @(posedge clk);
        #1;
        a_in = 32'h41;
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        #1;
        check("pre-reset count1", 32'(a_c1), 32'h2);
        check("pre-reset data1", a_out1, 32'h40);
        rst = 1'b0;
        #1;
        check("async reset out_valid", 32'(a_out_valid), 32'h0);
        check("async reset count0", 32'(a_c0), 32'h0);
        check("async reset count1", 32'(a_c1), 32'h0);
        check("async reset data1", a_out1, 32'h0);
        check("async reset in_ready", 32'(a_ready), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        a_out_ready = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("post-reset idle%0d valid", i), 32'(a_out_valid), 32'h0);
        end
        a_valid = 1'b1; a_in = 32'h42;
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        #1;
        check("post-reset data0", a_out0, 32'h42);
        check("post-reset data1", a_out1, 32'h42);
        check("post-reset count1", 32'(a_c1), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
